// File: rtl/mt9p031_frame_check.sv
// Receiver-side frame checker for the mt9p031 parallel sensor interface.
// Measures per-frame line width/count against expected geometry and sums pixels.
module mt9p031_frame_check #(
  parameter int DATA_WIDTH = 10,
  parameter int CNT_WIDTH  = 16,
  parameter int SUM_WIDTH  = 32
) (
  input  logic                  clk_pix,
  input  logic                  reset,
  input  logic                  i_fval,
  input  logic                  i_lval,
  input  logic [DATA_WIDTH-1:0] iv_pix_data,
  input  logic [CNT_WIDTH-1:0]  iv_exp_width,
  input  logic [CNT_WIDTH-1:0]  iv_exp_height,
  output logic                  o_frame_done,
  output logic [CNT_WIDTH-1:0]  ov_last_width,
  output logic [CNT_WIDTH-1:0]  ov_last_height,
  output logic [SUM_WIDTH-1:0]  ov_checksum,
  output logic                  o_width_err,
  output logic                  o_height_err,
  output logic                  o_lval_out_err,
  output logic [15:0]           ov_frame_cnt,
  output logic [15:0]           ov_err_frame_cnt
);

  typedef enum logic [1:0] {SYNC, IDLE, FRAME, DONE} state_t;

  state_t                 state_q;
  logic                   f1_q, f2_q, l1_q, pv2_q, primed_q, pend_q;
  logic [DATA_WIDTH-1:0]  d1_q;
  logic [CNT_WIDTH-1:0]   exp_w_q, exp_h_q, w_q, lines_q, lw_q;
  logic [SUM_WIDTH-1:0]   sum_q;
  logic                   werr_q;
  logic                   done_q, owerr_q, oherr_q, lerr_q;
  logic [CNT_WIDTH-1:0]   last_w_q, last_h_q;
  logic [SUM_WIDTH-1:0]   cks_q;
  logic [15:0]            fcnt_q, ecnt_q;

  logic                   pv, f_rise, f_fall, line_end, herr_d;
  logic [CNT_WIDTH-1:0]   w_inc_d, lines_inc_d;
  logic [SUM_WIDTH-1:0]   pix_ext_d;

  always_comb begin
    pv          = f1_q & l1_q;
    f_rise      = f1_q & ~f2_q;
    f_fall      = ~f1_q & f2_q;
    line_end    = pv2_q & ~pv;
    w_inc_d     = (w_q == '1) ? w_q : w_q + 1'b1;
    lines_inc_d = (lines_q == '1) ? lines_q : lines_q + 1'b1;
    pix_ext_d   = SUM_WIDTH'(d1_q);
    herr_d      = (lines_q != exp_h_q);
  end

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      state_q  <= SYNC;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
      l1_q     <= 1'b0;
      d1_q     <= '0;
      pv2_q    <= 1'b0;
      primed_q <= 1'b0;
      pend_q   <= 1'b0;
      exp_w_q  <= '0;
      exp_h_q  <= '0;
      w_q      <= '0;
      lines_q  <= '0;
      lw_q     <= '0;
      sum_q    <= '0;
      werr_q   <= 1'b0;
      done_q   <= 1'b0;
      last_w_q <= '0;
      last_h_q <= '0;
      cks_q    <= '0;
      owerr_q  <= 1'b0;
      oherr_q  <= 1'b0;
      lerr_q   <= 1'b0;
      fcnt_q   <= '0;
      ecnt_q   <= '0;
    end else begin
      f1_q     <= i_fval;
      f2_q     <= f1_q;
      l1_q     <= i_lval;
      d1_q     <= iv_pix_data;
      pv2_q    <= pv;
      primed_q <= 1'b1;
      done_q   <= 1'b0;
      if (state_q != SYNC && l1_q && !f1_q) lerr_q <= 1'b1;
      case (state_q)
        // f1 only reflects the real input once one edge has passed since reset
        SYNC: if (primed_q && !f1_q) state_q <= IDLE;
        IDLE: if (f_rise || pend_q) begin
          exp_w_q <= iv_exp_width;
          exp_h_q <= iv_exp_height;
          w_q     <= CNT_WIDTH'(pv);
          sum_q   <= pv ? pix_ext_d : '0;
          lines_q <= '0;
          lw_q    <= '0;
          werr_q  <= 1'b0;
          pend_q  <= 1'b0;
          state_q <= FRAME;
        end
        FRAME: begin
          if (pv) begin
            w_q   <= w_inc_d;
            sum_q <= sum_q + pix_ext_d;
          end
          if (line_end) begin
            lines_q <= lines_inc_d;
            lw_q    <= w_q;
            w_q     <= '0;
            if (w_q != exp_w_q) werr_q <= 1'b1;
          end
          if (f_fall) state_q <= DONE;
        end
        DONE: begin
          last_w_q <= lw_q;
          last_h_q <= lines_q;
          cks_q    <= sum_q;
          owerr_q  <= werr_q;
          oherr_q  <= herr_d;
          done_q   <= 1'b1;
          fcnt_q   <= fcnt_q + 16'd1;
          if ((werr_q || herr_d) && ecnt_q != 16'hFFFF) ecnt_q <= ecnt_q + 16'd1;
          // a one-cycle fval gap puts the next rising edge here; replay it from IDLE
          if (f_rise) pend_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= SYNC;
      endcase
    end
  end

  assign o_frame_done     = done_q;
  assign ov_last_width    = last_w_q;
  assign ov_last_height   = last_h_q;
  assign ov_checksum      = cks_q;
  assign o_width_err      = owerr_q;
  assign o_height_err     = oherr_q;
  assign o_lval_out_err   = lerr_q;
  assign ov_frame_cnt     = fcnt_q;
  assign ov_err_frame_cnt = ecnt_q;

endmodule

// File: tb/tb_mt9p031_frame_check.sv
// Scoreboard bench for mt9p031_frame_check: stimulus pushes per-frame expectations,
// a negedge monitor pops and compares whenever o_frame_done pulses.
module tb_mt9p031_frame_check;
  localparam int DW = 10, CW = 16, SW = 32;

  logic          clk_pix = 1'b0;
  logic          reset   = 1'b1;
  logic          fval = 1'b0, lval = 1'b0;
  logic [DW-1:0] pix = '0;
  logic [CW-1:0] exp_w = 16, exp_h = 16;
  logic          o_frame_done, o_width_err, o_height_err, o_lval_out_err;
  logic [CW-1:0] ov_last_width, ov_last_height;
  logic [SW-1:0] ov_checksum;
  logic [15:0]   ov_frame_cnt, ov_err_frame_cnt;

  mt9p031_frame_check #(.DATA_WIDTH(DW), .CNT_WIDTH(CW), .SUM_WIDTH(SW)) dut (
    .clk_pix(clk_pix), .reset(reset), .i_fval(fval), .i_lval(lval),
    .iv_pix_data(pix), .iv_exp_width(exp_w), .iv_exp_height(exp_h),
    .o_frame_done(o_frame_done), .ov_last_width(ov_last_width),
    .ov_last_height(ov_last_height), .ov_checksum(ov_checksum),
    .o_width_err(o_width_err), .o_height_err(o_height_err),
    .o_lval_out_err(o_lval_out_err), .ov_frame_cnt(ov_frame_cnt),
    .ov_err_frame_cnt(ov_err_frame_cnt));

  always #5 clk_pix = ~clk_pix;

  int cyc = 0;
  always @(posedge clk_pix) cyc <= cyc + 1;

  typedef struct {
    int          w, h;
    logic [31:0] cks;
    bit          werr, herr;
    int          fcnt, ecnt, ecyc;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_pass = 0, n_tot = 0;
  int   m_fcnt = 0, m_ecnt = 0;

  task automatic chk(input string name, input longint act, input longint expv);
    n_tot++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
  endtask

  // Monitor: one expectation per o_frame_done pulse
  always @(negedge clk_pix) begin
    if (!reset && o_frame_done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        me = q.pop_front();
        chk("done_cycle",  cyc,              me.ecyc);
        chk("last_width",  ov_last_width,    me.w);
        chk("last_height", ov_last_height,   me.h);
        chk("checksum",    ov_checksum,      me.cks);
        chk("width_err",   o_width_err,      me.werr);
        chk("height_err",  o_height_err,     me.herr);
        chk("frame_cnt",   ov_frame_cnt,     me.fcnt);
        chk("err_cnt",     ov_err_frame_cnt, me.ecnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pix);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},  o_frame_done,     0);
    chk({tag, "_fcnt"},  ov_frame_cnt,     0);
    chk({tag, "_ecnt"},  ov_err_frame_cnt, 0);
    chk({tag, "_cks"},   ov_checksum,      0);
    chk({tag, "_lerr"},  o_lval_out_err,   0);
    chk({tag, "_width"}, ov_last_width,    0);
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 50) begin tick(1); k++; end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    tick(1);
  endtask

  task automatic send_frame(input int nlines, input int wid, input int bad_line,
                            input int bad_w, input int pause_line, input int gap,
                            input int rst_line, input bit chg_exp);
    logic [31:0]   sum = 0;
    bit            werr = 0, aborted = 0;
    int            lastw = 0, lw;
    logic [CW-1:0] ew = exp_w, eh = exp_h;
    exp_t          e;
    fval = 1'b1;
    tick(2);
    for (int l = 0; l < nlines; l++) begin
      if (l == pause_line) tick(200);
      if (chg_exp && l == 1) begin exp_w = 5; exp_h = 3; end
      lw = (l == bad_line) ? bad_w : wid;
      for (int p = 0; p < lw; p++) begin
        lval = 1'b1;
        pix  = DW'($urandom_range(0, 1023));
        sum  = sum + 32'(pix);
        if (l == rst_line && p == 8) begin
          reset = 1'b1;
          tick(1);
          chk_zero("midrst");
          reset   = 1'b0;
          aborted = 1;
          m_fcnt  = 0;
          m_ecnt  = 0;
        end
        tick(1);
      end
      lval = 1'b0;
      tick(3);
      lastw = lw;
      if (lw != int'(ew)) werr = 1;
    end
    if (chg_exp) begin exp_w = ew; exp_h = eh; end
    fval = 1'b0;
    if (!aborted) begin
      m_fcnt    = (m_fcnt + 1) & 16'hFFFF;
      e.w       = lastw;
      e.h       = nlines;
      e.cks     = sum;
      e.werr    = werr;
      e.herr    = (nlines != int'(eh));
      if ((e.werr || e.herr) && m_ecnt < 16'hFFFF) m_ecnt++;
      e.fcnt    = m_fcnt;
      e.ecnt    = m_ecnt;
      e.ecyc    = cyc + 3;
      q.push_back(e);
    end
    tick(gap);
  endtask

  initial begin
    reset = 1'b1;
    tick(3);
    chk_zero("reset");
    reset = 1'b0;
    tick(3);

    // 20 nominal 16x16 frames
    repeat (20) send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    drain();

    // reset released mid-frame: that frame is discarded
    send_frame(16, 16, -1, 0, -1, 4, 5, 0);
    send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    // frame 3 has one 15-pixel line; frame 4 is clean again
    send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    send_frame(16, 16, 7, 15, -1, 4, -1, 0);
    send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    drain();

    // expected height 17 against 16-line frames
    reset = 1'b1;
    tick(2);
    reset  = 1'b0;
    m_fcnt = 0;
    m_ecnt = 0;
    tick(3);
    exp_h = 17;
    repeat (3) send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    drain();
    exp_h = 16;

    // lval outside fval between frames: sticky flag, no effect on sums
    chk("lerr_before", o_lval_out_err, 0);
    lval = 1'b1;
    pix  = 10'h3FF;
    tick(3);
    lval = 1'b0;
    tick(3);
    chk("lerr_set", o_lval_out_err, 1);
    send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    drain();
    chk("lerr_sticky", o_lval_out_err, 1);

    // 2000 ns pause mid-frame with exp_* changed mid-frame, then 1-cycle fval gaps
    send_frame(16, 16, -1, 0, 6, 1, -1, 1);
    send_frame(16, 16, -1, 0, -1, 1, -1, 0);
    send_frame(16, 16, -1, 0, -1, 4, -1, 0);
    drain();
    chk("queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks expected completion", n_tot);
    $fatal(1);
  end
endmodule
